// File: rtl/lfsr_rand_range.sv
// Pseudo-random number source for game logic: a free-running Fibonacci LFSR
// sampled on request and reduced into [0, MAX_VAL] by repeated subtraction.
module lfsr_rand_range #(
  parameter int              WIDTH   = 10,
  parameter logic [WIDTH-1:0] TAPS   = 10'b1001000000,
  parameter logic [WIDTH-1:0] SEED   = '1,
  parameter int              SHIFTS  = 10,
  parameter int              MAX_VAL = 600
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  output logic             busy,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_REDUCE = 2'd2;

  localparam logic [7:0]       CNT_LAST = 8'(SHIFTS - 1);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MODULUS  = WIDTH'(MAX_VAL + 1);

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur);
    return {cur[WIDTH-2:0], ^(cur & TAPS)};
  endfunction

  // Only ever applied while val > MAX_VAL, so the subtraction cannot wrap.
  function automatic logic [WIDTH-1:0] reduce_step(input logic [WIDTH-1:0] val);
    return val - MODULUS;
  endfunction

  logic [WIDTH-1:0] r_lfsr;
  logic [1:0]       r_state;
  logic [7:0]       r_cnt;
  logic [WIDTH-1:0] r_sample;
  logic [WIDTH-1:0] r_rnd;
  logic             r_rnd_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_lfsr_next;
  logic [1:0]       w_state_next;
  logic             w_in_range;

  assign w_in_range = (r_sample <= MAX_V);

  // A zero seed, or a zero register from any cause, falls back to SEED.
  always_comb begin
    w_lfsr_next = lfsr_step(r_lfsr);
    if (seed_load) begin
      w_lfsr_next = (seed != '0) ? seed : SEED;
    end else if (r_lfsr == '0) begin
      w_lfsr_next = SEED;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (req) w_state_next = ST_SHIFT;
      ST_SHIFT:  if (r_cnt == CNT_LAST) w_state_next = ST_REDUCE;
      ST_REDUCE: if (w_in_range) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr      <= SEED;
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_sample    <= '0;
      r_rnd       <= '0;
      r_rnd_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_lfsr      <= w_lfsr_next;
      r_state     <= w_state_next;
      r_busy      <= (w_state_next != ST_IDLE);
      r_rnd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) r_cnt <= 8'd0;
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt + 8'd1;
          // Capture what the LFSR registers on this same edge.
          if (r_cnt == CNT_LAST) r_sample <= w_lfsr_next;
        end
        ST_REDUCE: begin
          if (w_in_range) begin
            r_rnd       <= r_sample;
            r_rnd_valid <= 1'b1;
          end else begin
            r_sample <= reduce_step(r_sample);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign rnd_valid = r_rnd_valid;
  assign rnd       = r_rnd;

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Directed bench for lfsr_rand_range: three instances cover the default,
// SHIFTS=1/MAX_VAL=600 and SHIFTS=1/MAX_VAL=99 configurations.
module tb_lfsr_rand_range;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration
  logic       d_rst, d_seed_load, d_req, d_busy, d_valid;
  logic [9:0] d_seed, d_rnd;
  // SHIFTS=1, MAX_VAL=600
  logic       a_rst, a_seed_load, a_req, a_busy, a_valid;
  logic [9:0] a_seed, a_rnd;
  // SHIFTS=1, MAX_VAL=99
  logic       b_rst, b_seed_load, b_req, b_busy, b_valid;
  logic [9:0] b_seed, b_rnd;

  int checks   = 0;
  int failures = 0;

  lfsr_rand_range u_def (
    .clk(clk), .rst(d_rst), .seed_load(d_seed_load), .seed(d_seed), .req(d_req),
    .busy(d_busy), .rnd_valid(d_valid), .rnd(d_rnd)
  );

  lfsr_rand_range #(.SHIFTS(1), .MAX_VAL(600)) u_s1 (
    .clk(clk), .rst(a_rst), .seed_load(a_seed_load), .seed(a_seed), .req(a_req),
    .busy(a_busy), .rnd_valid(a_valid), .rnd(a_rnd)
  );

  lfsr_rand_range #(.SHIFTS(1), .MAX_VAL(99)) u_m99 (
    .clk(clk), .rst(b_rst), .seed_load(b_seed_load), .seed(b_seed), .req(b_req),
    .busy(b_busy), .rnd_valid(b_valid), .rnd(b_rnd)
  );

  // Independent reference of the default instance's LFSR (taps x^10+x^7+1).
  logic [9:0] sh_lfsr;
  always @(posedge clk or posedge d_rst) begin
    if (d_rst) sh_lfsr <= 10'h3FF;
    else if (d_seed_load) sh_lfsr <= (d_seed != 10'd0) ? d_seed : 10'h3FF;
    else if (sh_lfsr == 10'd0) sh_lfsr <= 10'h3FF;
    else sh_lfsr <= {sh_lfsr[8:0], sh_lfsr[9] ^ sh_lfsr[6]};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    d_rst = 1'b1; a_rst = 1'b1; b_rst = 1'b1;
    d_seed_load = 1'b0; a_seed_load = 1'b0; b_seed_load = 1'b0;
    d_req = 1'b0; a_req = 1'b0; b_req = 1'b0;
    d_seed = 10'd0; a_seed = 10'd0; b_seed = 10'd0;
    tick(); tick();
    checks++;
    if ({d_busy, d_valid, d_rnd} !== 12'd0) begin
      failures++; $display("FAIL reset_def got=%b exp=0", {d_busy, d_valid, d_rnd});
    end
    checks++;
    if ({a_busy, a_valid, a_rnd} !== 12'd0) begin
      failures++; $display("FAIL reset_s1 got=%b exp=0", {a_busy, a_valid, a_rnd});
    end
    checks++;
    if ({b_busy, b_valid, b_rnd} !== 12'd0) begin
      failures++; $display("FAIL reset_m99 got=%b exp=0", {b_busy, b_valid, b_rnd});
    end
    d_rst = 1'b0; a_rst = 1'b0; b_rst = 1'b0;
    tick();
  endtask

  // Seed 0x3FF advanced 10 times is 0x007, in range: rnd=7 at E11.
  task automatic test_default_latency;
    int bad;
    bad = 0;
    d_seed_load = 1'b1; d_seed = 10'h3FF; d_req = 1'b1;
    tick();  // E0
    d_seed_load = 1'b0; d_req = 1'b0;
    if (!(d_busy === 1'b1 && d_valid === 1'b0)) bad++;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (!(d_busy === 1'b1 && d_valid === 1'b0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL def_busy_window got=%0d bad cycles exp=0", bad);
    end
    tick();  // E11
    checks++;
    if ({d_valid, d_busy, d_rnd} !== {1'b1, 1'b0, 10'd7}) begin
      failures++; $display("FAIL def_result got valid=%b busy=%b rnd=%0d exp valid=1 busy=0 rnd=7",
                           d_valid, d_busy, d_rnd);
    end
    tick();  // E12
    checks++;
    if ({d_valid, d_rnd} !== {1'b0, 10'd7}) begin
      failures++; $display("FAIL def_hold got valid=%b rnd=%0d exp valid=0 rnd=7", d_valid, d_rnd);
    end
  endtask

  // Sample 1022, one subtraction of 601: rnd=421 at E3.
  task automatic test_shift1_one_sub;
    a_seed_load = 1'b1; a_seed = 10'h3FF; a_req = 1'b1;
    tick();  // E0
    a_seed_load = 1'b0; a_req = 1'b0;
    tick(); tick();  // E2
    checks++;
    if ({a_busy, a_valid} !== 2'b10) begin
      failures++; $display("FAIL s1_e2 got busy=%b valid=%b exp busy=1 valid=0", a_busy, a_valid);
    end
    tick();  // E3
    checks++;
    if ({a_valid, a_busy, a_rnd} !== {1'b1, 1'b0, 10'd421}) begin
      failures++; $display("FAIL s1_result got valid=%b busy=%b rnd=%0d exp valid=1 busy=0 rnd=421",
                           a_valid, a_busy, a_rnd);
    end
  endtask

  // Sample 1022 minus ten subtractions of 100: rnd=22 at E12.
  task automatic test_shift1_ten_sub;
    int bad;
    bad = 0;
    b_seed_load = 1'b1; b_seed = 10'h3FF; b_req = 1'b1;
    tick();  // E0
    b_seed_load = 1'b0; b_req = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (!(b_busy === 1'b1 && b_valid === 1'b0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL m99_busy_window got=%0d bad cycles exp=0", bad);
    end
    tick();  // E12
    checks++;
    if ({b_valid, b_busy, b_rnd} !== {1'b1, 1'b0, 10'd22}) begin
      failures++; $display("FAIL m99_result got valid=%b busy=%b rnd=%0d exp valid=1 busy=0 rnd=22",
                           b_valid, b_busy, b_rnd);
    end
  endtask

  task automatic test_lockup_guard;
    // Zero seed with req: LFSR becomes 0x3FF, so same result as seed 0x3FF.
    a_seed_load = 1'b1; a_seed = 10'd0; a_req = 1'b1;
    tick();
    a_seed_load = 1'b0; a_req = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({a_valid, a_rnd} !== {1'b1, 10'd421}) begin
      failures++; $display("FAIL zero_seed_s1 got valid=%b rnd=%0d exp valid=1 rnd=421", a_valid, a_rnd);
    end
    // Zero seed load, then 1023 free-run shifts back to 0x3FF before req.
    d_seed_load = 1'b1; d_seed = 10'd0;
    tick();
    d_seed_load = 1'b0;
    checks++;
    if (sh_lfsr !== 10'h3FF) begin
      failures++; $display("FAIL zero_seed_model got=%h exp=3ff", sh_lfsr);
    end
    repeat (1022) tick();
    d_req = 1'b1;
    tick();  // accept with LFSR back at 0x3FF
    d_req = 1'b0;
    repeat (11) tick();
    checks++;
    if ({d_valid, d_rnd} !== {1'b1, 10'd7}) begin
      failures++; $display("FAIL period_1023 got valid=%b rnd=%0d exp valid=1 rnd=7", d_valid, d_rnd);
    end
  endtask

  // Reload 0x3FF at E5: five shifts remain, sample 0x3E0=992 -> 391 at E12.
  task automatic test_reseed_in_flight;
    d_seed_load = 1'b1; d_seed = 10'h3FF; d_req = 1'b1;
    tick();  // E0
    d_seed_load = 1'b0; d_req = 1'b0;
    repeat (4) tick();
    d_seed_load = 1'b1; d_seed = 10'h3FF;
    tick();  // E5
    d_seed_load = 1'b0;
    repeat (6) tick();  // E11
    checks++;
    if ({d_busy, d_valid} !== 2'b10) begin
      failures++; $display("FAIL reseed_e11 got busy=%b valid=%b exp busy=1 valid=0", d_busy, d_valid);
    end
    tick();  // E12
    checks++;
    if ({d_valid, d_rnd} !== {1'b1, 10'd391}) begin
      failures++; $display("FAIL reseed_result got valid=%b rnd=%0d exp valid=1 rnd=391", d_valid, d_rnd);
    end
  endtask

  task automatic test_req_while_busy;
    int extra;
    extra = 0;
    d_seed_load = 1'b1; d_seed = 10'h3FF; d_req = 1'b1;
    tick();  // E0
    d_seed_load = 1'b0; d_req = 1'b0;
    tick(); tick();
    d_req = 1'b1;
    tick(); tick();  // E3, E4 see req while busy
    d_req = 1'b0;
    repeat (7) tick();  // E11
    checks++;
    if ({d_valid, d_rnd} !== {1'b1, 10'd7}) begin
      failures++; $display("FAIL busy_req_result got valid=%b rnd=%0d exp valid=1 rnd=7", d_valid, d_rnd);
    end
    for (int n = 0; n < 15; n++) begin
      tick();
      if (d_busy !== 1'b0 || d_valid !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++; $display("FAIL busy_req_queued got=%0d active cycles exp=0", extra);
    end
  endtask

  // req held high: second acceptance at E4, sample 0x3E0 -> 391 at E7.
  task automatic test_back_to_back;
    a_seed_load = 1'b1; a_seed = 10'h3FF; a_req = 1'b1;
    tick();  // E0
    a_seed_load = 1'b0;
    tick(); tick(); tick();  // E3
    checks++;
    if ({a_valid, a_busy, a_rnd} !== {1'b1, 1'b0, 10'd421}) begin
      failures++; $display("FAIL b2b_first got valid=%b busy=%b rnd=%0d exp valid=1 busy=0 rnd=421",
                           a_valid, a_busy, a_rnd);
    end
    tick();  // E4
    a_req = 1'b0;
    checks++;
    if ({a_busy, a_valid} !== 2'b10) begin
      failures++; $display("FAIL b2b_accept got busy=%b valid=%b exp busy=1 valid=0", a_busy, a_valid);
    end
    tick(); tick(); tick();  // E7
    checks++;
    if ({a_valid, a_rnd} !== {1'b1, 10'd391}) begin
      failures++; $display("FAIL b2b_second got valid=%b rnd=%0d exp valid=1 rnd=391", a_valid, a_rnd);
    end
  endtask

  task automatic test_reset_mid;
    int extra;
    extra = 0;
    b_seed_load = 1'b1; b_seed = 10'h3FF; b_req = 1'b1;
    tick();  // E0
    b_seed_load = 1'b0; b_req = 1'b0;
    repeat (5) tick();  // in REDUCE
    #2 b_rst = 1'b1;
    #1;
    checks++;
    if ({b_busy, b_valid, b_rnd} !== 12'd0) begin
      failures++; $display("FAIL rst_mid got busy=%b valid=%b rnd=%0d exp all 0", b_busy, b_valid, b_rnd);
    end
    tick();
    b_rst = 1'b0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (b_valid !== 1'b0 || b_busy !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++; $display("FAIL rst_mid_pending got=%0d active cycles exp=0", extra);
    end
  endtask

  task automatic test_random_draws;
    int valids, accepted, cyc, n, due;
    bit pend, acc, pre_busy;
    logic [9:0] cap, exp_rnd, last_rnd;
    valids = 0; accepted = 0; cyc = 0; n = 0; due = 0; pend = 0;
    cap = 10'd0; exp_rnd = 10'd0; last_rnd = d_rnd;
    while ((valids < 2000 || pend) && cyc < 40000) begin
      if (valids < 2000) d_req = 1'($urandom_range(0, 1));
      else d_req = 1'b0;
      pre_busy = d_busy;
      acc = d_req && !pre_busy;
      tick();
      cyc++;
      if (acc) begin
        accepted++; pend = 1; n = 0; due = 1000;
      end else if (pend) begin
        n++;
      end
      if (pend && n == 10) begin
        cap = sh_lfsr;
        exp_rnd = 10'(cap % 601);
        due = 11 + int'(cap) / 601;
      end
      if (d_valid) begin
        valids++;
        checks++;
        if (!pend || n != due || d_rnd !== exp_rnd || d_rnd > 10'd600) begin
          failures++; $display("FAIL rand_draw got rnd=%0d at cycle %0d exp rnd=%0d at cycle %0d",
                               d_rnd, n, exp_rnd, due);
        end
        pend = 0;
      end else begin
        if (d_rnd !== last_rnd) begin
          checks++; failures++;
          $display("FAIL rand_stable got=%0d exp=%0d", d_rnd, last_rnd);
        end
        if (pend && n > 12) begin
          checks++; failures++;
          $display("FAIL rand_timeout got no valid after %0d cycles exp<=12", n);
          pend = 0;
        end
      end
      last_rnd = d_rnd;
    end
    d_req = 1'b0;
    checks++;
    if (accepted != valids || valids < 2000) begin
      failures++; $display("FAIL rand_count got valids=%0d accepted=%0d exp equal and >=2000",
                           valids, accepted);
    end
  endtask

  initial begin
    test_reset();
    test_default_latency();
    test_shift1_one_sub();
    test_shift1_ten_sub();
    test_lockup_guard();
    test_reseed_in_flight();
    test_req_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random_draws();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
